// File: rtl/dmem_store_buffer_pkg.sv
// Shared definitions for the data-memory store buffer: drain FSM state
// encodings and the field widths of one buffered store entry.
package dmem_store_buffer_pkg;

    localparam int SB_DATA_W        = 32;
    localparam int SB_MASK_W        = 4;
    localparam int SB_AW_DEFAULT    = 32;
    localparam int SB_DEPTH_DEFAULT = 4;

    // Drain sequencer: IDLE waits for work, ISSUE pulses the write, WAIT
    // holds the entry on the bus until data_mem reports completion.
    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'd0,
        DRAIN_ISSUE = 2'd1,
        DRAIN_WAIT  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/dmem_store_buffer_sb_fifo.sv
// Circular store queue with head/tail/count bookkeeping and a per-entry
// word-address match vector used for load hazard detection.
module sb_fifo
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = SB_AW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [AW-1:0]        i_push_addr,
    input  logic [SB_DATA_W-1:0] i_push_data,
    input  logic [SB_MASK_W-1:0] i_push_mask,
    input  logic                 i_pop,
    input  logic [AW-1:0]        i_cmp_addr,
    output logic [AW-1:0]        o_head_addr,
    output logic [SB_DATA_W-1:0] o_head_data,
    output logic [SB_MASK_W-1:0] o_head_mask,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [DEPTH-1:0]     o_match
);

    localparam int            PW        = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW:0]   CNT_DEPTH = (PW+1)'(DEPTH);

    logic [AW-1:0]        r_addr [DEPTH];
    logic [SB_DATA_W-1:0] r_data [DEPTH];
    logic [SB_MASK_W-1:0] r_mask [DEPTH];
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [PW:0]          r_count;
    logic [PW-1:0]        w_offset [DEPTH];
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full    = (r_count == CNT_DEPTH);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_head_mask = r_mask[r_head];

    // Entry storage: written at the tail on an accepted push.
    // NOTE: the payload array has no reset; validity comes solely from head/count,
    // so clearing it would only cost flops and reset fan-out.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_addr[r_tail] <= i_push_addr;
            r_data[r_tail] <= i_push_data;
            r_mask[r_tail] <= i_push_mask;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_tail <= r_tail + PTR_ONE;
            if (w_do_pop)  r_head <= r_head + PTR_ONE;
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Word-granular address match against every currently valid entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_offset[i] = PW'(i) - r_head;
            o_match[i]  = ({1'b0, w_offset[i]} < r_count) &&
                          (r_addr[i][AW-1:2] == i_cmp_addr[AW-1:2]);
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the MEM stage and data_mem: stores retire in
// one cycle, drain one at a time in the background, loads bypass the queue
// but stall on a word hit until the matching store has drained.
module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = SB_AW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AW-1:0]        i_cpu_addr,
    input  logic [SB_DATA_W-1:0] i_cpu_write_data,
    input  logic                 i_cpu_memwrite,
    input  logic                 i_cpu_memread,
    input  logic [SB_MASK_W-1:0] i_cpu_sign_mask,
    output logic [SB_DATA_W-1:0] o_cpu_read_data,
    output logic                 o_cpu_stall,
    output logic [AW-1:0]        o_mem_addr,
    output logic [SB_DATA_W-1:0] o_mem_write_data,
    output logic                 o_mem_memwrite,
    output logic                 o_mem_memread,
    output logic [SB_MASK_W-1:0] o_mem_sign_mask,
    input  logic [SB_DATA_W-1:0] i_mem_read_data,
    input  logic                 i_mem_stall,
    output logic                 o_buf_empty
);

    drain_state_t         r_state;
    drain_state_t         w_state_nxt;
    logic                 r_seen_stall;
    logic                 w_seen_nxt;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [DEPTH-1:0]     w_match;
    logic [AW-1:0]        w_head_addr;
    logic [SB_DATA_W-1:0] w_head_data;
    logic [SB_MASK_W-1:0] w_head_mask;
    logic                 w_hit;
    logic                 w_load_req;
    logic                 w_busy;
    logic                 w_load_go;

    sb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (i_cpu_memwrite),
        .i_push_addr (i_cpu_addr),
        .i_push_data (i_cpu_write_data),
        .i_push_mask (i_cpu_sign_mask),
        .i_pop       (w_pop),
        .i_cmp_addr  (i_cpu_addr),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_head_mask (w_head_mask),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_match     (w_match)
    );

    assign w_hit      = |w_match;
    assign w_load_req = i_cpu_memread & ~w_hit;
    assign w_busy     = (r_state != DRAIN_IDLE);
    assign w_load_go  = w_load_req & ~w_busy & ~i_mem_stall;

    // Drain state register; reset abandons any write already handed to data_mem.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= DRAIN_IDLE;
            r_seen_stall <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_seen_stall <= w_seen_nxt;
        end
    end

    // Drain next-state: a missing load outranks starting a new drain, and
    // completion is the first stall-free edge after data_mem went busy.
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_seen_nxt  = r_seen_stall;
        w_pop       = 1'b0;
        unique case (r_state)
            DRAIN_IDLE: begin
                if (!w_empty && !i_mem_stall && !w_load_req) begin
                    w_state_nxt = DRAIN_ISSUE;
                end
            end
            DRAIN_ISSUE: begin
                w_seen_nxt  = i_mem_stall;
                w_state_nxt = DRAIN_WAIT;
            end
            DRAIN_WAIT: begin
                if (r_seen_stall && !i_mem_stall) begin
                    w_pop       = 1'b1;
                    w_seen_nxt  = 1'b0;
                    w_state_nxt = DRAIN_IDLE;
                end else if (i_mem_stall) begin
                    w_seen_nxt = 1'b1;
                end
            end
            default: w_state_nxt = DRAIN_IDLE;
        endcase
    end

    // Port muxing: the head entry owns the bus while draining, else the load path does.
    always_comb begin
        o_mem_addr       = i_cpu_addr;
        o_mem_write_data = i_cpu_write_data;
        o_mem_sign_mask  = i_cpu_sign_mask;
        if (w_busy) begin
            o_mem_addr       = w_head_addr;
            o_mem_write_data = w_head_data;
            o_mem_sign_mask  = w_head_mask;
        end
    end

    assign o_mem_memwrite  = rst_n & (r_state == DRAIN_ISSUE);
    assign o_mem_memread   = rst_n & w_load_go;
    assign o_cpu_stall     = rst_n & ((i_cpu_memwrite & w_full) |
                                      (i_cpu_memread & ~w_load_go));
    assign o_buf_empty     = ~rst_n | (w_empty & ~w_busy);
    assign o_cpu_read_data = i_mem_read_data;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: a stand-in data_mem, a transaction-level
// reference (queue of pending stores + program-order memory image) checked
// every cycle, directed scenarios with literal expectations, and a random phase.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;
    localparam logic [3:0] M_BYTE = 4'b0000;
    localparam logic [3:0] M_HALF = 4'b0001;
    localparam logic [3:0] M_WORD = 4'b0010;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr, cpu_write_data;
    logic        cpu_memwrite, cpu_memread;
    logic [3:0]  cpu_sign_mask;
    logic [31:0] o_cpu_read_data;
    logic        o_cpu_stall;
    logic [31:0] o_mem_addr, o_mem_write_data;
    logic        o_mem_memwrite, o_mem_memread;
    logic [3:0]  o_mem_sign_mask;
    logic [31:0] mem_read_data;
    logic        mem_stall;
    logic        o_buf_empty;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_cpu_addr       (cpu_addr),
        .i_cpu_write_data (cpu_write_data),
        .i_cpu_memwrite   (cpu_memwrite),
        .i_cpu_memread    (cpu_memread),
        .i_cpu_sign_mask  (cpu_sign_mask),
        .o_cpu_read_data  (o_cpu_read_data),
        .o_cpu_stall      (o_cpu_stall),
        .o_mem_addr       (o_mem_addr),
        .o_mem_write_data (o_mem_write_data),
        .o_mem_memwrite   (o_mem_memwrite),
        .o_mem_memread    (o_mem_memread),
        .o_mem_sign_mask  (o_mem_sign_mask),
        .i_mem_read_data  (mem_read_data),
        .i_mem_stall      (mem_stall),
        .o_buf_empty      (o_buf_empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Size code in mask[1:0]: 0 byte, 1 halfword, otherwise word; low data bits land in the lane.
    function automatic logic [31:0] apply_store(input logic [31:0] old, input logic [31:0] a,
                                                input logic [31:0] d, input logic [3:0] m);
        logic [31:0] w;
        w = old;
        case (m[1:0])
            2'd0:    w[8*a[1:0] +: 8]  = d[7:0];
            2'd1:    w[16*a[1] +: 16]  = d[15:0];
            default: w = d;
        endcase
        return w;
    endfunction

    // ---------------- data_mem stand-in: write keeps it busy for two cycles ----------------
    logic [31:0] dmem [1024];
    logic [1:0]  busy_cnt;
    logic        force_stall;
    bit          rand_stall_en;

    always @(posedge clk) begin
        if (o_mem_memwrite) begin
            dmem[o_mem_addr[11:2]] <= apply_store(dmem[o_mem_addr[11:2]], o_mem_addr,
                                                  o_mem_write_data, o_mem_sign_mask);
            busy_cnt <= 2'd2;
        end else if (busy_cnt != 2'd0) begin
            busy_cnt <= busy_cnt - 2'd1;
        end
    end

    assign mem_stall     = (busy_cnt != 2'd0) | force_stall;
    assign mem_read_data = dmem[o_mem_addr[11:2]];

    always @(posedge clk) begin
        #1;
        if (rand_stall_en) force_stall = ($urandom_range(0, 3) == 0);
    end

    // ---------------- reference model + per-cycle compare ----------------
    ent_t        q[$];
    logic [31:0] ref_mem [1024];
    bit          m_busy, m_pulse, m_seen;
    logic [31:0] wr_log[$];
    bit          hit, load_ok, exp_stall, do_push;
    ent_t        new_ent;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_memwrite", {31'b0, o_mem_memwrite}, 32'd0);
            check("rst_memread",  {31'b0, o_mem_memread},  32'd0);
            check("rst_stall",    {31'b0, o_cpu_stall},    32'd0);
            check("rst_empty",    {31'b0, o_buf_empty},    32'd1);
            q.delete();
            m_busy  = 1'b0;
            m_pulse = 1'b0;
            m_seen  = 1'b0;
        end else begin
            hit = 1'b0;
            foreach (q[i]) if (q[i].addr[31:2] == cpu_addr[31:2]) hit = 1'b1;
            load_ok   = cpu_memread && !hit && !m_busy && !mem_stall;
            exp_stall = (cpu_memwrite && q.size() == DEPTH) || (cpu_memread && !load_ok);
            check("cpu_stall",    {31'b0, o_cpu_stall},    {31'b0, exp_stall});
            check("mem_memwrite", {31'b0, o_mem_memwrite}, {31'b0, m_pulse});
            check("mem_memread",  {31'b0, o_mem_memread},  {31'b0, load_ok});
            check("buf_empty",    {31'b0, o_buf_empty},    {31'b0, (q.size() == 0 && !m_busy)});
            if (m_busy) begin
                check("drain_addr", o_mem_addr,       q[0].addr);
                check("drain_data", o_mem_write_data, q[0].data);
                check("drain_mask", {28'b0, o_mem_sign_mask}, {28'b0, q[0].mask});
            end else begin
                check("load_addr", o_mem_addr, cpu_addr);
                check("load_mask", {28'b0, o_mem_sign_mask}, {28'b0, cpu_sign_mask});
            end
            if (load_ok) check("load_data", o_cpu_read_data, ref_mem[cpu_addr[11:2]]);
            if (o_mem_memwrite) wr_log.push_back(o_mem_addr);

            // What the coming edge does: full is judged before any pop.
            do_push = cpu_memwrite && (q.size() < DEPTH);
            if (m_pulse) begin
                m_pulse = 1'b0;
                m_seen  = mem_stall;
            end else if (m_busy) begin
                if (m_seen && !mem_stall) begin
                    void'(q.pop_front());
                    m_busy = 1'b0;
                    m_seen = 1'b0;
                end else if (mem_stall) begin
                    m_seen = 1'b1;
                end
            end else if (q.size() > 0 && !mem_stall && !(cpu_memread && !hit)) begin
                m_busy  = 1'b1;
                m_pulse = 1'b1;
                m_seen  = 1'b0;
            end
            if (do_push) begin
                new_ent.addr = cpu_addr;
                new_ent.data = cpu_write_data;
                new_ent.mask = cpu_sign_mask;
                q.push_back(new_ent);
                ref_mem[cpu_addr[11:2]] = apply_store(ref_mem[cpu_addr[11:2]], cpu_addr,
                                                      cpu_write_data, cpu_sign_mask);
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic op(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, output int n_stall, output logic [31:0] rdata);
        cpu_addr       = a;
        cpu_write_data = d;
        cpu_sign_mask  = m;
        cpu_memwrite   = wr;
        cpu_memread    = rd;
        n_stall        = 0;
        rdata          = '0;
        forever begin
            @(negedge clk);
            if (!o_cpu_stall) begin
                rdata = o_cpu_read_data;
                break;
            end
            n_stall++;
            if (n_stall > 500) begin
                check("op_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_memwrite = 1'b0;
        cpu_memread  = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (o_buf_empty) break;
            n++;
            if (n > 1000) begin
                check("drain_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic random_op(input logic [31:0] base);
        int          n;
        logic [31:0] rd, a;
        logic [3:0]  m;
        a = base + ($urandom_range(0, 7) << 2);
        case ($urandom_range(0, 2))
            0:       begin m = M_BYTE; a = a + $urandom_range(0, 3); end
            1:       begin m = M_HALF; a = a + ($urandom_range(0, 1) << 1); end
            default: m = M_WORD;
        endcase
        if ($urandom_range(0, 1) == 0) op(1'b1, 1'b0, a, $urandom, m, n, rd);
        else                           op(1'b0, 1'b1, a, 32'd0, m, n, rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] rd;
        int          wr_before;

        for (int i = 0; i < 1024; i++) begin
            dmem[i]    = 32'd0;
            ref_mem[i] = 32'd0;
        end
        busy_cnt       = 2'd0;
        force_stall    = 1'b0;
        rand_stall_en  = 1'b0;

        // 1: reset held across a store request for two clocks.
        rst_n          = 1'b0;
        cpu_addr       = 32'h80;
        cpu_write_data = 32'hDEAD_BEEF;
        cpu_sign_mask  = M_WORD;
        cpu_memwrite   = 1'b1;
        cpu_memread    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        cpu_memwrite = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("t1_empty",    {31'b0, o_buf_empty},    32'd1);
            check("t1_memwrite", {31'b0, o_mem_memwrite}, 32'd0);
            check("t1_stall",    {31'b0, o_cpu_stall},    32'd0);
        end
        check("t1_no_write", dmem[32'h80 >> 2], 32'd0);
        @(posedge clk);
        #1;

        // 2: single word store.
        wr_log.delete();
        op(1'b1, 1'b0, 32'h40, 32'h1234_5678, M_WORD, n, rd);
        check("t2_retire_stalls", n, 32'd0);
        wait_empty();
        check("t2_pulses",  wr_log.size(), 32'd1);
        check("t2_addr",    wr_log[0], 32'h40);
        check("t2_memword", dmem[32'h40 >> 2], 32'h1234_5678);

        // 3: fill with data_mem held busy, fifth store must stall.
        wr_log.delete();
        force_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op(1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), M_WORD, n, rd);
            check("t3_accept", n, 32'd0);
        end
        cpu_addr = 32'h110; cpu_write_data = 32'hA000_0004; cpu_sign_mask = M_WORD;
        cpu_memwrite = 1'b1;
        @(negedge clk);
        check("t3_full_stall", {31'b0, o_cpu_stall}, 32'd1);
        @(posedge clk);
        #1;
        force_stall = 1'b0;
        op(1'b1, 1'b0, 32'h110, 32'hA000_0004, M_WORD, n, rd);
        wait_empty();
        check("t3_pulses", wr_log.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < wr_log.size()) check("t3_order", wr_log[i], 32'h100 + 32'(i * 4));
        end
        check("t3_word4", dmem[32'h110 >> 2], 32'hA000_0004);

        // 4: byte store then load of the same word must wait for the drain.
        op(1'b1, 1'b0, 32'h203, 32'h0000_00AB, M_BYTE, n, rd);
        op(1'b0, 1'b1, 32'h200, 32'd0, M_WORD, n, rd);
        check("t4_stalled", {31'b0, (n > 0)}, 32'd1);
        check("t4_load",    rd, 32'hAB00_0000);
        check("t4_empty",   {31'b0, o_buf_empty}, 32'd1);

        // 5: load to another word goes ahead of the pending store.
        wr_log.delete();
        op(1'b1, 1'b0, 32'h300, 32'h5555_AAAA, M_WORD, n, rd);
        wr_before = wr_log.size();
        op(1'b0, 1'b1, 32'h400, 32'd0, M_WORD, n, rd);
        check("t5_no_stall", n, 32'd0);
        check("t5_load_first", wr_log.size(), wr_before);
        wait_empty();
        check("t5_drained", dmem[32'h300 >> 2], 32'h5555_AAAA);

        // 6: random mix with random data_mem stalls: ten stores then a longer run.
        rand_stall_en = 1'b1;
        for (int s = 0; s < 10; ) begin
            op(1'b1, 1'b0, 32'h500 + ($urandom_range(0, 7) << 2), $urandom, M_WORD, n, rd);
            s++;
            if ($urandom_range(0, 1) == 0) random_op(32'h500);
        end
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                random_op(32'h500);
            end
        end
        rand_stall_en = 1'b0;
        @(posedge clk);
        #1;
        force_stall = 1'b0;
        wait_empty();
        for (int i = 0; i < 1024; i++) begin
            if (dmem[i] !== ref_mem[i]) check("t6_memimage", dmem[i], ref_mem[i]);
        end
        check("t6_region_sum", dmem[32'h500 >> 2] ^ dmem[32'h51C >> 2],
              ref_mem[32'h500 >> 2] ^ ref_mem[32'h51C >> 2]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
